// File: rtl/sync_fifo_param_pkg.sv
// Shared constants, types and helpers for the single-clock FIFO family.
package sync_fifo_param_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    // Encoding is {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic int fifo_ptr_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// Dual-port storage array: synchronous write port, asynchronous read port.
module sync_fifo_param_mem
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // No reset on the array: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO: occupancy count, almost flags, sticky
// overflow/underflow, synchronous flush and optional first-word-fall-through.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
    parameter bit FWFT               = 1'b0,
    parameter int ALMOST_FULL_LEVEL  = 14,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_increment,
    input  logic                  read_increment,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  write_full,
    output logic                  read_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = fifo_ptr_width(ADDR_WIDTH);
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] L_AF    = CW'(ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] L_AE    = CW'(ALMOST_EMPTY_LEVEL);

    if (!(ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL && ALMOST_FULL_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("sync_fifo_param: need ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= depth");
    end

    logic [CW-1:0]         r_wr_ptr, r_rd_ptr, r_count;
    logic                  r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
    logic                  w_wr_acc, w_rd_acc, w_flush;
    logic [CW-1:0]         w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_rd_word;
    fifo_op_e              w_op;

    assign w_flush  = reset | clear;
    // Acceptance uses the registered flags, i.e. occupancy before this edge.
    assign w_wr_acc = write_increment & ~r_full;
    assign w_rd_acc = read_increment & ~r_empty;
    assign w_op     = fifo_op_e'({w_wr_acc, w_rd_acc});

    always_comb begin
        w_cnt_nxt = r_count;
        case (w_op)
            OP_WR:   w_cnt_nxt = r_count + CW'(1);
            OP_RD:   w_cnt_nxt = r_count - CW'(1);
            default: w_cnt_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + CW'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + CW'(1);
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == L_DEPTH);
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= L_AF);
            r_ae    <= (w_cnt_nxt <= L_AE);
            if (write_increment & r_full)  r_ovf <= 1'b1;
            if (read_increment & r_empty)  r_udf <= 1'b1;
        end
    end

    sync_fifo_param_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc & ~w_flush),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (write_data),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_rd_word)
    );

    if (FWFT) begin : g_fwft
        assign read_data = r_empty ? '0 : w_rd_word;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] r_rd_data;
        // Async read sees pre-edge contents, so a same-address write returns the old word.
        always_ff @(posedge clk) begin
            if (w_flush)       r_rd_data <= '0;
            else if (w_rd_acc) r_rd_data <= w_rd_word;
        end
        assign read_data = r_rd_data;
    end

    assign write_full   = r_full;
    assign read_empty   = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
